// File: rtl/obstacle_slot_scheduler.sv
// Six-slot obstacle scheduler: timed spawns into free slots at pseudo-random lanes,
// per-frame advance and retirement at the screen bottom.
module obstacle_slot_scheduler #(
  parameter int unsigned NUM_SLOTS     = 6,
  parameter int unsigned SPAWN_PERIOD  = 40,
  parameter int unsigned SPEED         = 2,
  parameter int unsigned SCREEN_BOTTOM = 480,
  parameter int unsigned CAR_H         = 32,
  parameter int unsigned LANE_BASE     = 96,
  parameter int unsigned LANE_PITCH    = 32,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    upsig,
  input  logic                    enable,
  input  logic                    crash,
  output logic [NUM_SLOTS-1:0]    obstacle_on,
  output logic [NUM_SLOTS*8-1:0]  obstacle_x,
  output logic [NUM_SLOTS*10-1:0] obstacle_y,
  output logic                    spawn_pulse,
  output logic                    spawn_miss,
  output logic [2:0]              active_count
);

  localparam int unsigned SW = $clog2(NUM_SLOTS);

  typedef enum logic [1:0] {IDLE, RUN, FREEZE} state_t;

  state_t state, state_next;
  logic   tick, clear;

  logic [NUM_SLOTS-1:0] on_q, on_d;
  logic [7:0]           x_q [NUM_SLOTS];
  logic [7:0]           x_d [NUM_SLOTS];
  logic [9:0]           y_q [NUM_SLOTS];
  logic [9:0]           y_d [NUM_SLOTS];
  logic [7:0]           timer_q, timer_d;
  logic [7:0]           lfsr_q, lfsr_d, lfsr_nx;
  logic [1:0]           last_lane_q, last_lane_d;
  logic [SW-1:0]        last_slot_q, last_slot_d;
  logic                 spawn_d, miss_d;
  logic [2:0]           count_d;
  logic [10:0]          y_sum;
  logic                 found;
  logic [SW-1:0]        target;
  logic [1:0]           lane;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next-state logic; a stopped game outranks a crash
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN: begin
        if (!enable)    state_next = IDLE;
        else if (crash) state_next = FREEZE;
      end
      FREEZE:  if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: a tick only counts when no transition happens in the same cycle
  always_comb begin
    tick  = upsig && (state == RUN) && (state_next == RUN);
    clear = (state_next == IDLE);
  end

  always_comb begin
    lfsr_nx = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_comb begin
    on_d        = on_q;
    x_d         = x_q;
    y_d         = y_q;
    timer_d     = timer_q;
    lfsr_d      = lfsr_q;
    last_lane_d = last_lane_q;
    last_slot_d = last_slot_q;
    spawn_d     = 1'b0;
    miss_d      = 1'b0;
    y_sum       = '0;
    found       = 1'b0;
    target      = '0;
    lane        = '0;

    if (clear) begin
      on_d    = '0;
      timer_d = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        x_d[i] = '0;
        y_d[i] = '0;
      end
    end else if (tick) begin
      lfsr_d = lfsr_nx;

      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (on_q[i]) begin
          y_sum = {1'b0, y_q[i]} + 11'(SPEED);
          if (y_sum >= 11'(SCREEN_BOTTOM)) on_d[i] = 1'b0;
          else                             y_d[i] = y_sum[9:0];
        end
      end

      if (timer_q == 8'(SPAWN_PERIOD - 1)) begin
        timer_d = '0;
        // free-slot search uses pre-tick flags so a slot retiring now stays unavailable
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
          if (!on_q[i] && !found) begin
            found  = 1'b1;
            target = SW'(i);
          end
        end
        if (found) begin
          lane = lfsr_nx[1:0];
          if (lane == last_lane_q && on_q[last_slot_q] &&
              y_q[last_slot_q] < 10'(2 * CAR_H))
            lane = lane + 2'd1;
          for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (SW'(i) == target) begin
              on_d[i] = 1'b1;
              x_d[i]  = 8'(LANE_BASE + lane * LANE_PITCH);
              y_d[i]  = '0;
            end
          end
          last_lane_d = lane;
          last_slot_d = target;
          spawn_d     = 1'b1;
        end else begin
          miss_d = 1'b1;
        end
      end else begin
        timer_d = timer_q + 8'd1;
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++)
      count_d = count_d + 3'(on_d[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      on_q         <= '0;
      timer_q      <= '0;
      lfsr_q       <= LFSR_SEED;
      last_lane_q  <= '0;
      last_slot_q  <= '0;
      spawn_pulse  <= 1'b0;
      spawn_miss   <= 1'b0;
      active_count <= '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      on_q         <= on_d;
      timer_q      <= timer_d;
      lfsr_q       <= lfsr_d;
      last_lane_q  <= last_lane_d;
      last_slot_q  <= last_slot_d;
      spawn_pulse  <= spawn_d;
      spawn_miss   <= miss_d;
      active_count <= count_d;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

  // slot 0 occupies the most significant field of each bus
  always_comb begin
    obstacle_on = '0;
    obstacle_x  = '0;
    obstacle_y  = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      obstacle_on[NUM_SLOTS-1-i]             = on_q[i];
      obstacle_x[(NUM_SLOTS-1-i)*8 +: 8]     = x_q[i];
      obstacle_y[(NUM_SLOTS-1-i)*10 +: 10]   = y_q[i];
    end
  end

endmodule

// File: tb/tb_obstacle_slot_scheduler.sv
// Scoreboard bench: a slot-level reference model predicts every cycle's outputs;
// a monitor compares them one clock later.
module tb_obstacle_slot_scheduler;

  localparam int P      = 4;
  localparam int SPEED  = 2;
  localparam int BOTTOM = 480;

  logic        clk = 1'b0;
  logic        reset, upsig, enable, crash;
  logic [5:0]  obstacle_on;
  logic [47:0] obstacle_x;
  logic [59:0] obstacle_y;
  logic        spawn_pulse, spawn_miss;
  logic [2:0]  active_count;

  always #5 clk = ~clk;

  obstacle_slot_scheduler #(.SPAWN_PERIOD(P)) dut (
    .clk(clk), .reset(reset), .upsig(upsig), .enable(enable), .crash(crash),
    .obstacle_on(obstacle_on), .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
    .spawn_pulse(spawn_pulse), .spawn_miss(spawn_miss), .active_count(active_count)
  );

  typedef struct packed {
    logic [5:0]  on;
    logic [47:0] x;
    logic [59:0] y;
    logic        sp;
    logic        ms;
    logic [2:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_spawn = 0, n_miss = 0, n_bump = 0, n_retire = 0;

  // reference model: 0 = stopped, 1 = playing, 2 = frozen
  int         mode;
  bit         m_on [6];
  int         m_x  [6];
  int         m_y  [6];
  int         m_timer;
  logic [7:0] m_lfsr;
  int         m_last_lane, m_last_slot;
  bit         m_sp, m_ms;

  function automatic void clear_field();
    for (int i = 0; i < 6; i++) begin
      m_on[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_timer = 0;
  endfunction

  function automatic void frame_tick();
    bit pre_on [6];
    int pre_y  [6];
    int free_slot, lane;
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    for (int i = 0; i < 6; i++) begin
      pre_on[i] = m_on[i];
      pre_y[i]  = m_y[i];
    end
    for (int i = 0; i < 6; i++) begin
      if (pre_on[i]) begin
        if (pre_y[i] + SPEED >= BOTTOM) begin
          m_on[i] = 0;
          n_retire++;
        end else begin
          m_y[i] = pre_y[i] + SPEED;
        end
      end
    end
    if (m_timer == P - 1) begin
      m_timer   = 0;
      free_slot = -1;
      for (int i = 5; i >= 0; i--)
        if (!pre_on[i]) free_slot = i;
      if (free_slot < 0) begin
        m_ms = 1;
        n_miss++;
      end else begin
        lane = m_lfsr % 4;
        if (lane == m_last_lane && pre_on[m_last_slot] && pre_y[m_last_slot] < 64) begin
          lane = (lane + 1) % 4;
          n_bump++;
        end
        m_on[free_slot] = 1;
        m_x[free_slot]  = 96 + 32 * lane;
        m_y[free_slot]  = 0;
        m_last_lane     = lane;
        m_last_slot     = free_slot;
        m_sp            = 1;
        n_spawn++;
      end
    end else begin
      m_timer++;
    end
  endfunction

  function automatic void model_step(bit r, bit en, bit cr, bit up);
    int nxt;
    m_sp = 0;
    m_ms = 0;
    if (r) begin
      mode = 0;
      clear_field();
      m_lfsr      = 8'hA5;
      m_last_lane = 0;
      m_last_slot = 0;
      return;
    end
    nxt = mode;
    if (mode == 0 && en)          nxt = 1;
    else if (mode != 0 && !en)    nxt = 0;
    else if (mode == 1 && cr)     nxt = 2;
    if (nxt == 0)                              clear_field();
    else if (mode == 1 && nxt == 1 && up)      frame_tick();
    mode = nxt;
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e = '0;
    for (int i = 0; i < 6; i++) begin
      e.on[5-i]             = m_on[i];
      e.x[(5-i)*8 +: 8]     = m_x[i][7:0];
      e.y[(5-i)*10 +: 10]   = m_y[i][9:0];
      e.cnt                 = e.cnt + 3'(m_on[i]);
    end
    e.sp = m_sp;
    e.ms = m_ms;
    return e;
  endfunction

  task automatic drive(input bit r, input bit en, input bit cr, input bit up);
    @(negedge clk);
    reset  = r;
    enable = en;
    crash  = cr;
    upsig  = up;
    model_step(r, en, cr, up);
    exp_q.push_back(snapshot());
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("obstacle_on",  64'(obstacle_on),  64'(e.on));
        chk("obstacle_x",   64'(obstacle_x),   64'(e.x));
        chk("obstacle_y",   64'(obstacle_y),   64'(e.y));
        chk("pulses",       64'({spawn_pulse, spawn_miss}), 64'({e.sp, e.ms}));
        chk("active_count", 64'(active_count), 64'(e.cnt));
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1; enable = 1'b0; crash = 1'b0; upsig = 1'b0;
    repeat (3) drive(1, 0, 0, 0);
    // long run: fill, misses, retire coinciding with a due spawn, slot reuse
    repeat (1200) drive(0, 1, 0, $urandom_range(0, 2) == 0);
    // crash freezes the field; frozen until enable drops
    repeat (40) drive(0, 1, 1, $urandom_range(0, 1) == 0);
    repeat (10) drive(0, 1, 0, 1'b1);
    repeat (3)  drive(0, 0, 0, 1'b1);
    repeat (300) drive(0, 1, 0, $urandom_range(0, 2) == 0);
    // mixed control traffic
    repeat (3000) drive(0, $urandom_range(0, 49) != 0, $urandom_range(0, 199) == 0,
                        $urandom_range(0, 2) == 0);
    // reset during play with a coincident tick
    repeat (100) drive(0, 1, 0, $urandom_range(0, 1) == 0);
    drive(1, 1, 0, 1);
    drive(1, 1, 1, 1);
    repeat (60) drive(0, 1, 0, $urandom_range(0, 1) == 0);
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("model events: %0d spawns, %0d misses, %0d lane bumps, %0d retires",
             n_spawn, n_miss, n_bump, n_retire);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
